// File: rtl/keypad_debounce.sv
// Keypad debouncer: accepts a stable key value and emits a single-cycle code strobe.
// Optional auto-repeat while held is enabled with the KEYPAD_REPEAT_EN macro.
module keypad_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_down,
  input  logic [3:0] key_raw,
  output logic [3:0] code,
  output logic       code_valid,
  output logic [1:0] state
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject out-of-range configurations at elaboration time
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 1..255");
  end
  if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > 255) begin : g_bad_repeat
    $error("REPEAT_CYCLES out of range 1..255");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state_r, state_nxt;
  logic [3:0]       cand_r, cand_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             emit_nxt;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rpt_r, rpt_nxt;
`endif

  // Next-state, counter and emission decode
  always_comb begin
    state_nxt = state_r;
    cand_nxt  = cand_r;
    cnt_nxt   = cnt_r;
    emit_nxt  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_nxt   = rpt_r;
`endif
    case (state_r)
      IDLE: begin
        if (key_down) begin
          cand_nxt  = key_raw;
          cnt_nxt   = '0;
          state_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!key_down || (key_raw != cand_r)) begin
          state_nxt = IDLE;
        end else if (cnt_r == DB_LAST) begin
          state_nxt = HELD;
          emit_nxt  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          rpt_nxt   = '0;
`endif
        end else begin
          cnt_nxt = cnt_r + CNT_W'(1);
        end
      end
      HELD: begin
        if (!key_down) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        // Repeat counter only advances while the key stays down in HELD
        else if (rpt_r == RPT_LAST) begin
          emit_nxt = 1'b1;
          rpt_nxt  = '0;
        end else begin
          rpt_nxt = rpt_r + CNT_W'(1);
        end
`endif
      end
      RELEASE: begin
        if (key_down) begin
          state_nxt = HELD;
        end else if (cnt_r == DB_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_r + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cand_r     <= 4'h0;
      cnt_r      <= '0;
      code       <= 4'hF;
      code_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_r      <= '0;
`endif
    end else begin
      state_r    <= state_nxt;
      cand_r     <= cand_nxt;
      cnt_r      <= cnt_nxt;
      code       <= emit_nxt ? cand_r : 4'hF;
      code_valid <= emit_nxt;
`ifdef KEYPAD_REPEAT_EN
      rpt_r      <= rpt_nxt;
`endif
    end
  end

  assign state = 2'(state_r);

endmodule

// File: tb/tb_keypad_debounce.sv
// Self-checking bench for keypad_debounce: directed scenarios plus random bouncing
// checked against a history-based model of the debounce rules.
module tb_keypad_debounce;

  localparam int unsigned D = 4;
  localparam int unsigned R = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       key_down = 1'b0;
  logic [3:0] key_raw = 4'h0;
  logic [3:0] code;
  logic       code_valid;
  logic [1:0] state;

  int n_assert = 0;
  int n_fail   = 0;

  keypad_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .reset_n(reset_n), .key_down(key_down), .key_raw(key_raw),
    .code(code), .code_valid(code_valid), .state(state)
  );

  always #5 clk = ~clk;

  // Model: runs of matching samples decide press/release acceptance
  bit         pressed;
  int         run, zrun, since;
  logic [3:0] mcand;
  bit         m_emit;
  int         pulses;
  logic [3:0] last_code;
  logic [3:0] seen[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pressed = 0; run = 0; zrun = 0; since = 0; mcand = 4'h0; m_emit = 0;
  endtask

  task automatic model_edge(input bit kd, input logic [3:0] kr);
    m_emit = 0;
    if (!pressed) begin
      if (run == 0) begin
        if (kd) begin mcand = kr; run = 1; end
      end else if (kd && kr == mcand) begin
        run++;
        if (run == D + 1) begin pressed = 1; zrun = 0; since = 0; m_emit = 1; end
      end else begin
        run = 0;
      end
    end else if (kd) begin
`ifdef KEYPAD_REPEAT_EN
      if (zrun == 0) begin
        since++;
        if (since == R) begin since = 0; m_emit = 1; end
      end
`endif
      zrun = 0;
    end else begin
      zrun++;
      if (zrun == D + 1) begin pressed = 0; run = 0; end
    end
  endtask

  function automatic logic [1:0] m_state();
    if (!pressed) return (run == 0) ? 2'd0 : 2'd1;
    return (zrun == 0) ? 2'd2 : 2'd3;
  endfunction

  task automatic step(input bit kd, input logic [3:0] kr);
    key_down = kd;
    key_raw  = kr;
    @(posedge clk);
    model_edge(kd, kr);
    #1;
    chk("state", 8'(state), 8'(m_state()));
    chk("valid", 8'(code_valid), 8'(m_emit));
    chk("code", 8'(code), 8'(m_emit ? mcand : 4'hF));
    if (code_valid === 1'b1) begin
      pulses++;
      last_code = code;
      seen.push_back(code);
    end
  endtask

  task automatic hold(input bit kd, input logic [3:0] kr, input int n);
    for (int i = 0; i < n; i++) step(kd, kr);
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_state", 8'(state), 8'h0);
    chk("rst_valid", 8'(code_valid), 8'h0);
    chk("rst_code", 8'(code), 8'h0F);
    @(posedge clk);
    #1;
    chk("rst_hold_state", 8'(state), 8'h0);
    chk("rst_hold_valid", 8'(code_valid), 8'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    int p0;
    model_reset();
    pulses = 0;
    async_reset();

    // Clean press: pulse only in cycle 5
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 4'h6);
      chk("clean_valid", 8'(code_valid), (i == 4) ? 8'h1 : 8'h0);
      chk("clean_code", 8'(code), (i == 4) ? 8'h6 : 8'h0F);
    end
    hold(1'b0, 4'h0, D + 2);
    chk("clean_idle", 8'(state), 8'h0);

    // Press bounce: too short to accept
    p0 = pulses;
    hold(1'b1, 4'h3, 2);
    step(1'b0, 4'h0);
    chk("bounce_state", 8'(state), 8'h0);
    hold(1'b0, 4'h0, 3);
    chk("bounce_pulses", 8'(pulses - p0), 8'h0);

    // Value change during debounce: single emission of the new value
    p0 = pulses;
    hold(1'b1, 4'h6, 2);
    hold(1'b1, 4'h4, 8);
    chk("change_pulses", 8'(pulses - p0), 8'h1);
    chk("change_code", 8'(last_code), 8'h4);
    hold(1'b0, 4'h0, 6);

    // Release bounce: no second pulse
    hold(1'b1, 4'h6, 6);
    p0 = pulses;
    hold(1'b0, 4'h0, 2);
    hold(1'b1, 4'h6, 3);
    hold(1'b0, 4'h0, 6);
    chk("relb_pulses", 8'(pulses - p0), 8'h0);
    chk("relb_state", 8'(state), 8'h0);

    // Key value F is emitted like any other
    hold(1'b1, 4'hF, D + 1);
    chk("keyF_valid", 8'(code_valid), 8'h1);
    chk("keyF_code", 8'(code), 8'h0F);
    hold(1'b0, 4'h0, 6);

    // Sequence 6,4,3 then reset mid-debounce and mid-held
    seen.delete();
    hold(1'b1, 4'h6, 6); hold(1'b0, 4'h0, 6);
    hold(1'b1, 4'h4, 6); hold(1'b0, 4'h0, 6);
    hold(1'b1, 4'h3, 6); hold(1'b0, 4'h0, 6);
    chk("seq_len", 8'(seen.size()), 8'h3);
    if (seen.size() == 3) begin
      chk("seq0", 8'(seen[0]), 8'h6);
      chk("seq1", 8'(seen[1]), 8'h4);
      chk("seq2", 8'(seen[2]), 8'h3);
    end
    p0 = pulses;
    hold(1'b1, 4'h5, 2);
    async_reset();
    chk("rst_db_pulses", 8'(pulses - p0), 8'h0);
    hold(1'b1, 4'h5, 8);
    async_reset();
    hold(1'b0, 4'h0, 3);

    // Long hold: repeat pulses only with the repeat feature
    hold(1'b1, 4'h2, D + 1);
    chk("long_first", 8'(code_valid), 8'h1);
    p0 = pulses;
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 4'h2);
`ifdef KEYPAD_REPEAT_EN
      chk("rpt_valid", 8'(code_valid), (k % R == 0) ? 8'h1 : 8'h0);
`else
      chk("norpt_valid", 8'(code_valid), 8'h0);
`endif
    end
`ifdef KEYPAD_REPEAT_EN
    chk("rpt_count", 8'(pulses - p0), 8'h2);
`else
    chk("norpt_count", 8'(pulses - p0), 8'h0);
`endif
    hold(1'b0, 4'h0, 6);

    // Random bouncing presses against the model
    for (int s = 0; s < 150; s++) begin
      logic [3:0] kv;
      int n1;
      kv = 4'($urandom_range(0, 15));
      n1 = int'($urandom_range(1, 12));
      for (int i = 0; i < n1; i++) begin
        if ($urandom_range(0, 19) == 0) kv = 4'($urandom_range(0, 15));
        step($urandom_range(0, 9) != 0, kv);
      end
      hold(1'b0, kv, int'($urandom_range(1, 8)));
      if ($urandom_range(0, 29) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
